ysyx_22040895_fetch_queue: RTL and testbench

//  Parametrised, handshaked successor to the ifu: replaces the same-cycle inst_i path with a request/response

---
 rtl/ysyx_22040895_fq_pkg.sv | 15 +
 rtl/ysyx_22040895_fq_ram.sv | 39 +++
 rtl/ysyx_22040895_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22040895_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_fq_pkg.sv
// Shared widths, reset address and queue state encoding for the fetch queue.
package ysyx_22040895_fq_pkg;

  localparam int YSYX_22040895_INST_W = 32;  // instruction bus width
  localparam int YSYX_22040895_ADDR_W = 64;  // instruction address bus width

  localparam logic [63:0] FQ_RESET_PC = 64'h8000_0000;

  // RUN issues fetches; DRAIN swallows responses still owed for a discarded stream.
  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_e;

endpackage

// File: rtl/ysyx_22040895_fq_ram.sv
// Payload storage for the fetch queue: pc is written when a slot is allocated,
// the instruction when its response arrives; the head entry is read asynchronously.
module ysyx_22040895_fq_ram #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              pc_we_i,
  input  logic [PTR_W-1:0]  pc_waddr_i,
  input  logic [ADDR_W-1:0] pc_wdata_i,
  input  logic              inst_we_i,
  input  logic [PTR_W-1:0]  inst_waddr_i,
  input  logic [INST_W-1:0] inst_wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rd_pc_o,
  output logic [INST_W-1:0] rd_inst_o
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  // Capture the pc of a newly allocated slot.
  // NOTE: storage arrays carry no reset; the valid/filled bits in the top decide
  // whether an entry means anything, so resetting payload would only add logic.
  always_ff @(posedge clk) begin
    if (pc_we_i) pc_mem[pc_waddr_i] <= pc_wdata_i;
  end

  // Capture the fetched instruction into the slot its response belongs to.
  always_ff @(posedge clk) begin
    if (inst_we_i) inst_mem[inst_waddr_i] <= inst_wdata_i;
  end

  assign rd_pc_o   = pc_mem[raddr_i];
  assign rd_inst_o = inst_mem[raddr_i];

endmodule

// File: rtl/ysyx_22040895_fetch_queue.sv
// In-order instruction prefetch queue between instruction memory and the idu.
// Optional macro YSYX_22040895_FQ_BYPASS_EN: a response for an unfilled head slot
// is forwarded straight to the output in the same cycle.
module ysyx_22040895_fetch_queue
  import ysyx_22040895_fq_pkg::*;
#(
  parameter int               ADDR_W   = YSYX_22040895_ADDR_W,
  parameter int               INST_W   = YSYX_22040895_INST_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC),
  parameter int               PTR_W    = $clog2(DEPTH),
  parameter int               CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic [DEPTH-1:0]  valid_q, valid_d, filled_q, filled_d;
  fq_state_e         state_q, state_d;

  logic              alloc, rsp_keep, fill_we, deq;
  logic              head_valid, head_filled, bypass_hit, out_valid;
  logic [ADDR_W-1:0] ram_pc;
  logic [INST_W-1:0] ram_inst;

  assign req_valid_o = ~rst & (state_q == FQ_RUN) & (count_q < CNT_W'(DEPTH)) & ~redirect_i;
  assign req_addr_o  = pc_q;
  assign alloc       = req_valid_o & req_ready_i;

  // A response belongs to the oldest unfilled slot unless it is owed to a flushed stream.
  assign rsp_keep    = ~rst & rsp_valid_i & (drop_q == '0) & (pend_q != '0);
  assign head_valid  = valid_q[head_q];
  assign head_filled = filled_q[head_q];

`ifdef YSYX_22040895_FQ_BYPASS_EN
  // An unfilled head is necessarily the oldest unfilled slot, so a kept response is its data.
  assign bypass_hit = head_valid & ~head_filled & rsp_keep;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid   = ~rst & head_valid & (head_filled | bypass_hit);
  assign deq         = out_valid & out_ready_i & ~redirect_i;
  assign fill_we     = rsp_keep & ~redirect_i & ~(bypass_hit & out_ready_i);

  assign out_valid_o = out_valid;
  assign out_pc_o    = out_valid ? ram_pc : '0;
  assign out_inst_o  = out_valid ? (bypass_hit ? rsp_data_i : ram_inst) : '0;
  assign count_o     = count_q;

  ysyx_22040895_fq_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk          (clk),
    .pc_we_i      (alloc),
    .pc_waddr_i   (tail_q),
    .pc_wdata_i   (pc_q),
    .inst_we_i    (fill_we),
    .inst_waddr_i (fill_q),
    .inst_wdata_i (rsp_data_i),
    .raddr_i      (head_q),
    .rd_pc_o      (ram_pc),
    .rd_inst_o    (ram_inst)
  );

  // Next-state for pointers, slot flags, counters and the RUN/DRAIN controller.
  // NOTE: every _d is given its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    filled_d = filled_q;
    state_d  = state_q;

    if (redirect_i) begin
      // Flush everything; responses already owed for unfilled slots must be swallowed.
      valid_d  = '0;
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      pc_d     = redirect_pc_i;
      drop_d   = drop_q + pend_q
               - CNT_W'(rsp_valid_i && ((drop_q | pend_q) != '0));
      state_d  = ((drop_d != '0) || (state_q == FQ_DRAIN)) ? FQ_DRAIN : FQ_RUN;
    end else begin
      if (rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (rsp_keep) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      if (deq) begin
        valid_d[head_q]  = 1'b0;
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      if (alloc) begin
        valid_d[tail_q]  = 1'b1;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        pc_d             = pc_q + ADDR_W'(4);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(deq);
      pend_d  = pend_q + CNT_W'(alloc) - CNT_W'(rsp_keep);
      // Leave DRAIN only once the counter register already reads zero.
      if ((state_q == FQ_DRAIN) && (drop_q == '0)) state_d = FQ_RUN;
    end
  end

  // State registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      valid_q  <= '0;
      filled_q <= '0;
      state_q  <= FQ_RUN;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      filled_q <= filled_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_fetch_queue.sv
// Directed bench for the fetch queue: a 1-cycle-latency memory model returning
// inst = pc[31:0], a delivery monitor, and hand-computed expectations.
module tb_ysyx_22040895_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_o, req_ready_i;
  logic [63:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem_q[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_inst[$];
  bit          mem_en  = 1'b1;
  int          req_cnt = 0;

`ifdef YSYX_22040895_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ysyx_22040895_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: records accepted requests at negedge, answers one per cycle just after the edge.
  initial begin
    logic [63:0] a;
    rsp_valid_i = 1'b0;
    rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst && req_valid_o && req_ready_i) begin
        mem_q.push_back(req_addr_o);
        req_cnt++;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        mem_q.delete();
        rsp_valid_i = 1'b0;
      end else if (mem_en && mem_q.size() > 0) begin
        a           = mem_q.pop_front();
        rsp_valid_i = 1'b1;
        rsp_data_i  = a[31:0];
      end else begin
        rsp_valid_i = 1'b0;
      end
    end
  end

  // Delivery monitor: an out handshake in a redirect cycle is discarded by the idu.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid_o && out_ready_i && !redirect_i) begin
        got_pc.push_back(out_pc_o);
        got_inst.push_back(out_inst_o);
      end
    end
  end

  task automatic do_reset(input bit men, input bit ordy);
    rst         = 1'b1;
    redirect_i  = 1'b0;
    mem_en      = men;
    out_ready_i = ordy;
    step();
    step();
    step();
    rst     = 1'b0;
    req_cnt = 0;
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic wait_deliv(input int n, input string tag);
    int k = 0;
    while (got_pc.size() < n && k < 40) begin
      step();
      k++;
    end
    check(tag, 64'(got_pc.size() >= n), 64'd1);
  endtask

  function automatic logic [63:0] dpc(input int i);
    return (got_pc.size() > i) ? got_pc[i] : 64'hdead;
  endfunction

  function automatic logic [63:0] dinst(input int i);
    return (got_inst.size() > i) ? 64'(got_inst[i]) : 64'hdead;
  endfunction

  initial begin
    req_ready_i   = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    out_ready_i   = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_out_pc", out_pc_o, 64'd0);
    check("rst_out_inst", 64'(out_inst_o), 64'd0);

    // 1: streaming, one instruction per cycle
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    check("t1_c0_req_valid", 64'(req_valid_o), 64'd1);
    check("t1_c0_req_addr", req_addr_o, 64'h8000_0000);
    check("t1_c0_out_valid", 64'(out_valid_o), 64'd0);
    step();
    @(negedge clk);
    check("t1_c1_req_addr", req_addr_o, 64'h8000_0004);
    check("t1_c1_out_valid", 64'(out_valid_o), 64'(BYP));
    step();
    @(negedge clk);
    check("t1_c2_out_valid", 64'(out_valid_o), 64'd1);
    check("t1_c2_out_pc", out_pc_o, BYP ? 64'h8000_0004 : 64'h8000_0000);
    repeat (8) step();
    check("t1_deliv_cnt", 64'(got_pc.size()), BYP ? 64'd9 : 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_pc%0d", i), dpc(i), 64'h8000_0000 + 64'(4 * i));
      check($sformatf("t1_inst%0d", i), dinst(i), 64'h8000_0000 + 64'(4 * i));
    end

    // 2: idu stalled, queue fills to DEPTH, then drains in order
    do_reset(1'b1, 1'b0);
    repeat (8) step();
    @(negedge clk);
    check("t2_full_count", 64'(count_o), 64'd4);
    check("t2_full_req_valid", 64'(req_valid_o), 64'd0);
    check("t2_req_cnt", 64'(req_cnt), 64'd4);
    check("t2_full_out_pc", out_pc_o, 64'h8000_0000);
    step();
    out_ready_i = 1'b1;
    @(negedge clk);
    check("t2_deq_full_no_req", 64'(req_valid_o), 64'd0);
    check("t2_deq_out_valid", 64'(out_valid_o), 64'd1);
    step();
    @(negedge clk);
    check("t2_resume_req_valid", 64'(req_valid_o), 64'd1);
    check("t2_resume_addr", req_addr_o, 64'h8000_0010);
    repeat (8) step();
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_pc%0d", i), dpc(i), 64'h8000_0000 + 64'(4 * i));

    // 3: redirect with three unfilled slots outstanding
    do_reset(1'b0, 1'b1);
    step();
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_1000;
    @(negedge clk);
    check("t3_redir_no_req", 64'(req_valid_o), 64'd0);
    check("t3_count_before", 64'(count_o), 64'd3);
    mem_en = 1'b1;
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    check("t3_drain_no_req", 64'(req_valid_o), 64'd0);
    check("t3_drain_count", 64'(count_o), 64'd0);
    wait_deliv(1, "t3_deliv_timeout");
    check("t3_first_pc", dpc(0), 64'h8000_1000);
    check("t3_first_inst", dinst(0), 64'h8000_1000);

    // 4: redirect coincident with a response, two unfilled slots
    do_reset(1'b0, 1'b1);
    step();
    @(negedge clk);
    mem_en = 1'b1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_4000;
    @(negedge clk);
    check("t4_redir_rsp", 64'(rsp_valid_i), 64'd1);
    check("t4_count_before", 64'(count_o), 64'd2);
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    check("t4_drain_no_req", 64'(req_valid_o), 64'd0);
    wait_deliv(2, "t4_deliv_timeout");
    check("t4_first_pc", dpc(0), 64'h8000_4000);
    check("t4_first_inst", dinst(0), 64'h8000_4000);
    check("t4_second_pc", dpc(1), 64'h8000_4004);

    // 5: back-to-back redirects while draining
    do_reset(1'b0, 1'b1);
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_2000;
    step();
    redirect_pc_i = 64'h8000_3000;
    @(negedge clk);
    check("t5_second_redir_no_req", 64'(req_valid_o), 64'd0);
    mem_en = 1'b1;
    step();
    redirect_i = 1'b0;
    wait_deliv(2, "t5_deliv_timeout");
    check("t5_first_pc", dpc(0), 64'h8000_3000);
    check("t5_first_inst", dinst(0), 64'h8000_3000);
    check("t5_second_pc", dpc(1), 64'h8000_3004);

    // 6: asynchronous reset between edges mid-stream
    do_reset(1'b1, 1'b1);
    repeat (5) step();
    #1;
    check("t6_mid_out_valid", 64'(out_valid_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_out_valid", 64'(out_valid_o), 64'd0);
    check("t6_async_req_valid", 64'(req_valid_o), 64'd0);
    check("t6_async_count", 64'(count_o), 64'd0);
    check("t6_async_out_pc", out_pc_o, 64'd0);
    check("t6_async_out_inst", 64'(out_inst_o), 64'd0);
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    check("t6_restart_addr", req_addr_o, 64'h8000_0000);
    wait_deliv(1, "t6_deliv_timeout");
    check("t6_restart_pc", dpc(0), 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
